// File: rtl/board_tx_ctrl.sv
// board_tx_ctrl
//   Sends a board snapshot to a byte-wide UART transmitter as a framed
//   packet and decodes single-byte move commands coming back from a UART
//   receiver.
//
//   Frame layout: HDR_BYTE, total_size/8 data bytes (MSB first), XOR checksum
//   of the data bytes. Each byte takes SEND -> GAP -> WAIT; WAIT holds until
//   the transmitter is idle. A request that arrives while a frame is in
//   progress is parked in a shadow register (latest wins). It is launched
//   directly after the current frame completes.
//
//   Ports
//     clk, rst        : clock, asynchronous active-high reset
//     i_board         : board snapshot to transmit
//     i_board_stb     : one-cycle send request
//     i_tx_busy       : transmitter busy flag
//     o_tx_data       : byte for the transmitter (held outside SEND)
//     o_tx_stb        : one-cycle transmitter load strobe
//     i_rx_data       : received byte
//     i_rx_valid      : qualifies i_rx_data
//     o_move          : decoded move (0 up, 1 left, 2 down, 3 right)
//     o_move_valid    : one-cycle pulse qualifying o_move
//     o_busy          : frame in progress
//     o_frame_done    : one-cycle pulse when the last byte has been accepted
module board_tx_ctrl #(
    parameter int unsigned total_size = 192,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [total_size-1:0] i_board,
    input  logic                  i_board_stb,
    input  logic                  i_tx_busy,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_stb,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [1:0]            o_move,
    output logic                  o_move_valid,
    output logic                  o_busy,
    output logic                  o_frame_done
);
    localparam int unsigned   NB        = total_size / 8;
    localparam int unsigned   NBYTES    = NB + 2;
    localparam int unsigned   CW        = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(NB);
    localparam logic [CW-1:0] FRAME_LEN = CW'(NBYTES);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [total_size-1:0] frame_q, frame_d;
    logic [total_size-1:0] shadow_q, shadow_d;
    logic                  pend_q, pend_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            txd_q, txd_d;
    logic [1:0]            move_q, move_d;
    logic                  mvld_q, mvld_d;
    logic [7:0]            cur_byte;

    // cnt_q counts bytes already sent. The frame register is shifted left
    // after each data byte, so the next data byte is always its top byte.
    always_comb begin
        if (cnt_q == '0) begin
            cur_byte = HDR_BYTE;
        end else if (cnt_q > LAST_DATA) begin
            cur_byte = csum_q;
        end else begin
            cur_byte = frame_q[total_size-1 -: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        csum_d       = csum_q;
        txd_d        = txd_q;
        o_tx_stb     = 1'b0;
        o_frame_done = 1'b0;

        // Requests during a frame, including the completion cycle, are parked.
        if (i_board_stb && (state_q != S_IDLE)) begin
            pend_d   = 1'b1;
            shadow_d = i_board;
        end

        case (state_q)
            S_IDLE: begin
                if (i_board_stb) begin
                    frame_d = i_board;
                    cnt_d   = '0;
                    csum_d  = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                o_tx_stb = 1'b1;
                txd_d    = cur_byte;
                cnt_d    = cnt_q + CW'(1);
                if ((cnt_q != '0) && (cnt_q <= LAST_DATA)) begin
                    csum_d  = csum_q ^ cur_byte;
                    frame_d = frame_q << 8;
                end
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!i_tx_busy) begin
                    if (cnt_q != FRAME_LEN) begin
                        state_d = S_SEND;
                    end else begin
                        o_frame_done = 1'b1;
                        // A request in this very cycle is newer than the shadow.
                        if (i_board_stb || pend_q) begin
                            frame_d = i_board_stb ? i_board : shadow_q;
                            pend_d  = 1'b0;
                            cnt_d   = '0;
                            csum_d  = '0;
                            state_d = S_SEND;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Move decode is independent of the transmit FSM.
    always_comb begin
        move_d = move_q;
        mvld_d = 1'b0;
        if (i_rx_valid) begin
            case (i_rx_data)
                8'h77: begin move_d = 2'd0; mvld_d = 1'b1; end
                8'h61: begin move_d = 2'd1; mvld_d = 1'b1; end
                8'h73: begin move_d = 2'd2; mvld_d = 1'b1; end
                8'h64: begin move_d = 2'd3; mvld_d = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            csum_q   <= '0;
            txd_q    <= '0;
            move_q   <= '0;
            mvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            txd_q    <= txd_d;
            move_q   <= move_d;
            mvld_q   <= mvld_d;
        end
    end

    assign o_tx_data    = (state_q == S_SEND) ? cur_byte : txd_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_move       = move_q;
    assign o_move_valid = mvld_q;

endmodule

// File: tb/tb_board_tx_ctrl.sv
module tb_board_tx_ctrl;
    localparam int TS = 192;
    localparam int NB = TS / 8;
    localparam int NF = NB + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TS-1:0] i_board = '0;
    logic          i_board_stb = 1'b0;
    logic          i_tx_busy = 1'b0;
    logic [7:0]    o_tx_data;
    logic          o_tx_stb;
    logic [7:0]    i_rx_data = '0;
    logic          i_rx_valid = 1'b0;
    logic [1:0]    o_move;
    logic          o_move_valid;
    logic          o_busy;
    logic          o_frame_done;

    board_tx_ctrl #(.total_size(TS), .HDR_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_board      (i_board),
        .i_board_stb  (i_board_stb),
        .i_tx_busy    (i_tx_busy),
        .o_tx_data    (o_tx_data),
        .o_tx_stb     (o_tx_stb),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_move       (o_move),
        .o_move_valid (o_move_valid),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // observation logs
    logic [7:0] txq[$];
    int         stb_cyc[$];
    logic [1:0] mvq[$];
    int         mv_cyc[$];
    int         done_cnt;
    int         busy_cnt;
    int         first_busy;
    int         cyc = 0;
    int         t_stb;

    // reference data
    logic [7:0] exp_q[$];
    logic [1:0] exp_mv[$];

    // UART model: busy for uart_len cycles after each accepted byte
    int uart_len = 0;
    int uart_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        txq.delete(); stb_cyc.delete(); mvq.delete(); mv_cyc.delete();
        exp_q.delete(); exp_mv.delete();
        done_cnt = 0; busy_cnt = 0; first_busy = -1;
    endtask

    // Called at a falling edge with this cycle's inputs applied.
    task automatic step();
        #1;
        if (o_tx_stb) begin
            txq.push_back(o_tx_data);
            stb_cyc.push_back(cyc);
            uart_cnt = uart_len;
        end
        if (o_frame_done) done_cnt++;
        if (o_busy) begin
            if (busy_cnt == 0) first_busy = cyc;
            busy_cnt++;
        end
        if (o_move_valid) begin
            mvq.push_back(o_move);
            mv_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
        i_board_stb = 1'b0;
        i_rx_valid  = 1'b0;
        i_tx_busy   = (uart_cnt > 0);
        if (uart_cnt > 0) uart_cnt--;
    endtask

    task automatic start(input logic [TS-1:0] b);
        i_board = b;
        i_board_stb = 1'b1;
        t_stb = cyc;
        step();
    endtask

    task automatic run_frames(input int nframes, input int budget);
        int n = 0;
        while (done_cnt < nframes && n < budget) begin
            step();
            n++;
        end
        check("frame_timeout", 64'(done_cnt >= nframes), 64'd1);
        for (int i = 0; i < 5; i++) step();
    endtask

    // Frame from the board: header, bytes MSB first, XOR of data bytes.
    task automatic add_frame(input logic [TS-1:0] b);
        logic [7:0]    x;
        logic [TS-1:0] t;
        x = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 1; k <= NB; k++) begin
            t = b >> (TS - 8 * k);
            exp_q.push_back(t[7:0]);
            x = x ^ t[7:0];
        end
        exp_q.push_back(x);
    endtask

    task automatic cmp_frames(input string tag);
        check({tag, "_len"}, 64'(txq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 64'(txq[i]), 64'(exp_q[i]));
    endtask

    function automatic logic [TS-1:0] rnd_board();
        logic [TS-1:0] b;
        b = '0;
        for (int i = 0; i < TS / 32; i++) b = {b[TS-33:0], 32'($urandom)};
        return b;
    endfunction

    task automatic model_rx(input logic [7:0] d);
        string keys;
        keys = "wasd";
        for (int j = 0; j < 4; j++)
            if (keys[j] == d) exp_mv.push_back(2'(j));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TS-1:0] ba, bx, by;
        logic [7:0]    rxb[5];
        logic [7:0]    d;
        int            n;

        // reset state
        @(negedge clk);
        #1;
        check("rst_tx_stb", 64'(o_tx_stb), 64'd0);
        check("rst_tx_data", 64'(o_tx_data), 64'h00);
        check("rst_move", 64'(o_move), 64'd0);
        check("rst_move_valid", 64'(o_move_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_frame_done", 64'(o_frame_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step(); step();

        // single set tile, slow transmitter
        clear_logs();
        uart_len = 10;
        ba = {144'd0, 12'd256, 36'd0};
        add_frame(ba);
        start(ba);
        run_frames(1, 2000);
        cmp_frames("tile");
        if (txq.size() == NF) begin
            check("tile_b19", 64'(txq[19]), 64'h10);
            check("tile_csum", 64'(txq[NF-1]), 64'h10);
        end
        check("tile_done_cnt", 64'(done_cnt), 64'd1);
        check("tile_latency", 64'(stb_cyc.size() > 0 ? stb_cyc[0] - t_stb : -1), 64'd1);

        // all ones, transmitter never busy
        clear_logs();
        uart_len = 0;
        ba = '1;
        add_frame(ba);
        start(ba);
        run_frames(1, 400);
        cmp_frames("ones");
        for (int i = 1; i < stb_cyc.size(); i++)
            check($sformatf("ones_stride%0d", i), 64'(stb_cyc[i] - stb_cyc[i-1]), 64'd3);
        check("ones_busy_cycles", 64'(busy_cnt), 64'd78);
        check("ones_busy_start", 64'(first_busy - t_stb), 64'd1);
        check("ones_done_cnt", 64'(done_cnt), 64'd1);

        // random boards, random transmitter speed
        for (int it = 0; it < 3; it++) begin
            clear_logs();
            uart_len = $urandom_range(0, 4);
            ba = rnd_board();
            add_frame(ba);
            start(ba);
            run_frames(1, 1000);
            cmp_frames($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_done", it), 64'(done_cnt), 64'd1);
        end

        // two requests during a frame: only the latest is sent, no idle gap
        clear_logs();
        uart_len = 0;
        ba = rnd_board(); bx = rnd_board(); by = rnd_board();
        add_frame(ba);
        add_frame(by);
        start(ba);
        while (cyc < t_stb + 10) step();
        i_board = bx; i_board_stb = 1'b1; step();
        while (cyc < t_stb + 20) step();
        i_board = by; i_board_stb = 1'b1; step();
        run_frames(2, 600);
        cmp_frames("pend");
        check("pend_done_cnt", 64'(done_cnt), 64'd2);
        check("pend_busy_cycles", 64'(busy_cnt), 64'd156);
        if (stb_cyc.size() > NF)
            check("pend_gap", 64'(stb_cyc[NF] - stb_cyc[NF-1]), 64'd3);

        // request arriving in the completion cycle
        clear_logs();
        uart_len = 0;
        ba = rnd_board(); by = rnd_board();
        add_frame(ba);
        add_frame(by);
        start(ba);
        while (cyc < t_stb + 78) step();
        i_board = by; i_board_stb = 1'b1; step();
        check("edge_done_seen", 64'(done_cnt), 64'd1);
        run_frames(2, 600);
        cmp_frames("edge");
        check("edge_done_cnt", 64'(done_cnt), 64'd2);
        check("edge_busy_cycles", 64'(busy_cnt), 64'd156);

        // move decode during a frame
        clear_logs();
        uart_len = 1;
        ba = rnd_board();
        add_frame(ba);
        start(ba);
        while (cyc < t_stb + 5) step();
        rxb[0] = 8'h77; rxb[1] = 8'h61; rxb[2] = 8'h73; rxb[3] = 8'h64; rxb[4] = 8'h41;
        n = cyc;
        for (int i = 0; i < 5; i++) begin
            i_rx_data = rxb[i];
            i_rx_valid = 1'b1;
            model_rx(rxb[i]);
            step();
        end
        run_frames(1, 1000);
        cmp_frames("mvtx");
        check("mv_count", 64'(mvq.size()), 64'(exp_mv.size()));
        for (int i = 0; i < mvq.size() && i < exp_mv.size(); i++)
            check($sformatf("mv%0d", i), 64'(mvq[i]), 64'(exp_mv[i]));
        if (mv_cyc.size() > 0) check("mv_latency", 64'(mv_cyc[0] - n), 64'd1);
        check("mv_hold", 64'(o_move), 64'd3);

        // random receive bytes, mix of commands and noise
        clear_logs();
        for (int i = 0; i < 24; i++) begin
            rxb[0] = 8'h77; rxb[1] = 8'h61; rxb[2] = 8'h73; rxb[3] = 8'h64;
            d = ($urandom_range(0, 1) == 1) ? rxb[$urandom_range(0, 3)] : 8'($urandom);
            i_rx_data = d;
            i_rx_valid = ($urandom_range(0, 3) != 0);
            if (i_rx_valid) model_rx(d);
            step();
        end
        step(); step();
        check("rxr_count", 64'(mvq.size()), 64'(exp_mv.size()));
        for (int i = 0; i < mvq.size() && i < exp_mv.size(); i++)
            check($sformatf("rxr%0d", i), 64'(mvq[i]), 64'(exp_mv[i]));

        // reset mid-frame after five bytes
        clear_logs();
        uart_len = 2;
        ba = rnd_board();
        start(ba);
        n = 0;
        while (txq.size() < 5 && n < 300) begin step(); n++; end
        check("arst_progress", 64'(txq.size()), 64'd5);
        check("arst_pre_busy", 64'(o_busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_tx_stb", 64'(o_tx_stb), 64'd0);
        check("arst_tx_data", 64'(o_tx_data), 64'h00);
        check("arst_move", 64'(o_move), 64'd0);
        check("arst_move_valid", 64'(o_move_valid), 64'd0);
        check("arst_frame_done", 64'(o_frame_done), 64'd0);
        @(negedge clk);
        uart_cnt = 0;
        i_tx_busy = 1'b0;
        step(); step();
        rst = 1'b0;
        clear_logs();
        for (int i = 0; i < 10; i++) step();
        check("arst_quiet_tx", 64'(txq.size()), 64'd0);
        check("arst_quiet_busy", 64'(busy_cnt), 64'd0);
        ba = rnd_board();
        add_frame(ba);
        start(ba);
        run_frames(1, 1000);
        cmp_frames("arst_new");
        if (txq.size() > 0) check("arst_new_hdr", 64'(txq[0]), 64'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/board_tx_ctrl.md
BOARD_TX_CTRL -- requirements
Module: board_tx_ctrl

Interface
REQ-001 SHALL have parameter total_size, default 192, meaning board width in bits (16 tiles x 12 bits); total_size SHALL be a multiple of 8.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, meaning the frame start byte.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_board  input  total_size  board snapshot to transmit.
REQ-006 i_board_stb  input  1  one-cycle request to send i_board.
REQ-007 i_tx_busy  input  1  busy flag from byte UART transmitter.
REQ-008 o_tx_data  output  8  byte presented to UART transmitter.
REQ-009 o_tx_stb  output  1  one-cycle load strobe to UART transmitter.
REQ-010 i_rx_data  input  8  received byte from UART receiver.
REQ-011 i_rx_valid  input  1  one-cycle valid for i_rx_data.
REQ-012 o_move  output  2  decoded move: 0 up, 1 left, 2 down, 3 right.
REQ-013 o_move_valid  output  1  one-cycle pulse qualifying o_move.
REQ-014 o_busy  output  1  frame in progress.
REQ-015 o_frame_done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 Frame SHALL be N = total_size/8 + 2 bytes: HDR_BYTE; data bytes 1..total_size/8, byte k = i_board[total_size-1-8(k-1) -: 8] (MSB first); checksum = XOR of all data bytes (header excluded).
REQ-017 FSM states SHALL be IDLE, SEND, GAP, WAIT; o_busy SHALL be 1 in every state except IDLE.
REQ-018 IDLE: i_board_stb SHALL capture i_board into the frame register, clear byte counter and checksum, go to SEND.
REQ-019 SEND (one cycle): o_tx_stb=1, o_tx_data = current byte; go to GAP; counter increments; checksum accumulates data bytes only.
REQ-020 GAP (one cycle): i_tx_busy ignored; go to WAIT.
REQ-021 WAIT: stay while i_tx_busy=1; when 0, go to SEND if bytes remain, else pulse o_frame_done one cycle and go to IDLE (or per REQ-023).
REQ-022 Latency: i_board_stb in cycle T (IDLE) -> o_tx_stb with HDR_BYTE in cycle T+1; with i_tx_busy held 0, stride between o_tx_stb pulses SHALL be 3 cycles.
REQ-023 i_board_stb while o_busy=1 SHALL set a pending flag and overwrite a shadow board register (latest wins); on frame completion with pending set, shadow SHALL load into frame register, pending clears, FSM goes directly to SEND (o_frame_done still pulses, o_busy stays 1).
REQ-024 i_board_stb in the completion cycle SHALL be treated as pending (no frame lost).
REQ-025 o_tx_stb SHALL never assert outside SEND; o_tx_data SHALL hold its value outside SEND.
REQ-026 RX decode SHALL run independently of the TX FSM: i_rx_valid with 0x77/0x61/0x73/0x64 ('w','a','s','d') -> o_move 0/1/2/3 and o_move_valid pulse the next cycle; any other byte ignored; o_move holds last value.
REQ-027 Back-to-back i_rx_valid cycles SHALL each produce one decoded pulse.

Reset
REQ-028 On rst: state IDLE; o_tx_stb, o_move_valid, o_frame_done, o_busy = 0; o_tx_data = 8'h00; o_move = 2'd0; pending, counter, checksum, frame and shadow registers cleared.
REQ-029 rst mid-frame SHALL abort immediately; no further o_tx_stb until a new i_board_stb after rst deasserts.

Verification
REQ-030 i_board = {144'd0, 12'd256, 36'd0}, stb, busy model 10 cycles/byte -> 26 bytes: A5, bytes 1-18 = 00, byte 19 = 10, bytes 20-24 = 00, checksum 10; one o_frame_done.
REQ-031 i_tx_busy tied 0, board all-ones -> o_tx_stb every 3 cycles, bytes A5, 24xFF, checksum 00; o_busy high exactly 78 cycles from T+1.
REQ-032 Two stb pulses (boards X then Y) during an active frame -> exactly one extra frame containing Y, starting without IDLE gap.
REQ-033 i_rx_valid bytes 77,61,73,64,41 consecutive -> o_move 0,1,2,3 with four pulses, nothing for 41; concurrent TX frame unaffected.
REQ-034 rst asserted after byte 5 sent -> all outputs reset asynchronously; next stb produces full frame starting with A5.
